serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock.
//  Counterpart of the parallel ripple-carry adder datapath; full-subtractor cell plus one borrow flop.
//  Sits beside the ALU adder where area matters more than latency; start/ready/done handshake.
// PARAMETERS
//  WIDTH   5   operand/result width in bits (>=2)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      synchronous reset, active-low
//  start    in   1      request; accepted only when ready=1
//  a        in   WIDTH  minuend, sampled on accepted start
//  b        in   WIDTH  subtrahend, sampled on accepted start
//  ready    out  1      1 in IDLE only
//  done     out  1      one-cycle pulse: diff/borrow valid
//  diff     out  WIDTH  a - b mod 2^WIDTH; held until next accepted start
//  borrow   out  1      1 iff unsigned a < b; held with diff
//  ovf      out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, ready=1, done=0, diff=0, borrow=0, ovf=0, count=0.
//  - FSM: IDLE -> RUN on start&ready; RUN -> DONE after WIDTH bit-steps; DONE -> IDLE next edge.
//  - Load edge (IDLE, start=1): sra<=a, srb<=b, bflop<=0, count<=0, ready drops next cycle.
//  - RUN, each edge: cell(a0=sra[0], b0=srb[0], bin=bflop) -> d, bout;
//    sra,srb shift right 1; result reg shifts right with d inserted at MSB; bflop<=bout; count++.
//  - Cell: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin).
//  - At count==WIDTH-1 step: diff<=final result, borrow<=bout, state<=DONE.
//  - Latency: start accepted at edge k -> done=1 in cycle after edge k+WIDTH; ready=1 after edge k+WIDTH+1.
//  - done high exactly one cycle (state DONE); diff/borrow stable from done until next load.
//  - diff not updated bit-by-bit: internal shift reg only; outputs change only at finishing edge.
//  - start while ready=0 (RUN or DONE): ignored, not queued; a/b changes during RUN ignored.
//  - Back-to-back: start held high -> re-accepted in IDLE cycle after DONE (period WIDTH+2).
//  - Reset mid-RUN: operation aborted, all outputs to reset values, no done pulse.
//  - Widths: no extension; diff exactly WIDTH bits, borrow is the final borrow-out.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: ovf port present; at finishing edge ovf <= a[W-1]^b[W-1] & (a[W-1]^diff[W-1])
//    using latched operand sign bits; held with diff; reset 0.
//  Not defined: ovf port absent; no sign-bit latches.
// STRUCTURE
//  Package serial_sub_pkg: state_t enum {IDLE, RUN, DONE}; CNT_W = $clog2(WIDTH) helper fn.
//  Sub-module full_subtractor (a, b, bin -> d, bout), gate-level xor/and/or, instantiated once.
//  Top: FSM, counter, two operand shift regs, result shift reg, borrow flop.
// TESTING (WIDTH=5)
//  T1 a=20,b=7 -> done 6 edges after start edge, diff=13 (01101), borrow=0.
//  T2 a=7,b=20 -> diff=19 (10011), borrow=1; a=0,b=1 -> diff=31, borrow=1; a=31,b=31 -> 0,0.
//  T3 start pulsed again 2 cycles into RUN with a=1,b=1 -> ignored; result from first op only.
//  T4 rst_n=0 at 3rd RUN edge -> ready=1, diff=0, borrow=0, no done pulse thereafter.
//  T5 start held high, pairs (10,3),(3,10) -> done every 7 cycles, diffs 7 then 25, borrows 0,1.
//  T6 (OVF_EN) a=01111,b=10000 -> diff=11111, ovf=1; a=5,b=3 -> ovf=0.
//  Exhaustive sweep a,b in 0..31 vs reference {borrow,diff} = {1'b0,a}-{1'b0,b}.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The step counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough for WIDTH >= 2.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column needs to borrow.
// Purely combinational, no latency, no flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb;

    assign axb  = a ^ b;
    assign d    = axb ^ bin;
    assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: done pulses WIDTH+1 cycles after an accepted start; start is ignored unless ready.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sra_q, sra_d;
    logic [WIDTH-1:0] srb_q, srb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bflop_q, bflop_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             cell_d, cell_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .a    (sra_q[0]),
        .b    (srb_q[0]),
        .bin  (bflop_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sra_d    = sra_q;
        srb_d    = srb_q;
        res_d    = res_q;
        bflop_d  = bflop_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sra_d   = a;
                    srb_d   = b;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                sra_d   = {1'b0, sra_q[WIDTH-1:1]};
                srb_d   = {1'b0, srb_q[WIDTH-1:1]};
                res_d   = {cell_d, res_q[WIDTH-1:1]};
                bflop_d = cell_bout;
                cnt_d   = cnt_q + 1'b1;
                // Outputs are only published on the last step, never bit-by-bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_d;
                    borrow_d = cell_bout;
                    state_d  = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (sa_q ^ sb_q) & (sa_q ^ cell_d);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sra_q    <= '0;
            srb_q    <= '0;
            res_q    <= '0;
            bflop_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sra_q    <= sra_d;
            srb_q    <= srb_d;
            res_q    <= res_d;
            bflop_q  <= bflop_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
